fetch_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: widths, opcodes and the fetch-entry record.
package cpu_pkg;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;

  localparam logic [3:0] OPC_LOAD = 4'b0000;
  localparam logic [3:0] OPC_ADD  = 4'b0010;
  localparam logic [3:0] OPC_SUB  = 4'b0011;
  localparam logic [3:0] OPC_AND  = 4'b0100;
  localparam logic [3:0] OPC_OR   = 4'b0101;
  localparam logic [3:0] OPC_HALT = 4'b0111;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 12,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared too so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, addresses the instruction ROM and queues
// {pc, instr} entries for decode. Redirects from execute flush the queue.
// Optional HALT detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit import cpu_pkg::*; #(
  parameter int         ADDR_W      = cpu_pkg::ADDR_W,
  parameter int         INSTR_W     = cpu_pkg::INSTR_W,
  parameter int         DEPTH       = 2,
  parameter logic [3:0] HALT_OPCODE = OPC_HALT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               halted
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count;
  logic              head_valid;
  entry_t            head;
  entry_t            new_entry;
  logic              pop;
  logic              push;
  logic              halt_hit;
  logic              is_halt_opc;

  assign is_halt_opc = (imem_instr[INSTR_W-1 -: 4] == HALT_OPCODE);
  assign new_entry   = '{pc: fetch_pc_q, instr: imem_instr};

`ifdef FETCH_HALT_DETECT_EN
  logic halted_q, halted_d;
  assign halted = halted_q;
`else
  logic halt_opc_unused;
  assign halt_opc_unused = is_halt_opc;
  assign halted          = 1'b0;
`endif

  // Handshake, push decision and next PC; a redirect overrides everything.
  always_comb begin
    pop        = head_valid & out_ready;
    push       = en & ~halted & ~redirect_valid & ((count < CNT_W'(DEPTH)) | pop);
`ifdef FETCH_HALT_DETECT_EN
    halt_hit   = push & is_halt_opc;
    halted_d   = halted_q;
`else
    halt_hit   = 1'b0;
`endif
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_addr;
`ifdef FETCH_HALT_DETECT_EN
      halted_d   = 1'b0;
`endif
    end else if (push) begin
      if (halt_hit) begin
`ifdef FETCH_HALT_DETECT_EN
        halted_d = 1'b1;
`endif
      end else begin
        fetch_pc_d = fetch_pc_q + 1'b1;
      end
    end
  end

  // PC (and halt flag when present) registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= '0;
`ifdef FETCH_HALT_DETECT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
`ifdef FETCH_HALT_DETECT_EN
      halted_q   <= halted_d;
`endif
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INSTR_W)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .din        (new_entry),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign imem_addr = fetch_pc_q;
  assign out_valid = head_valid;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based reference model of the fetch stage,
// a per-cycle compare process, directed scenarios and a randomized run.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] imem_addr;
  logic [7:0] imem_instr;
  logic       redirect_valid = 1'b0;
  logic [3:0] redirect_addr = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_instr;
  logic [3:0] out_pc;
  logic       halted;

  logic [7:0] rom [16];
  logic [7:0] demo [8];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // reference model state: queue of {pc, instr}, PC, halt flag
  logic [11:0] mq [$];
  int          mpc = 0;
  bit          mhalt = 1'b0;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  assign imem_instr = rom[imem_addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances at each clock edge from the rules of the stage.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mpc   = 0;
      mhalt = 1'b0;
    end else begin
      bit do_pop, do_push;
      do_pop = (mq.size() > 0) && out_ready;
      if (redirect_valid) begin
        mq.delete();
        mpc   = int'(redirect_addr);
        mhalt = 1'b0;
      end else begin
        do_push = en && !mhalt && ((mq.size() < DEPTH) || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back({mpc[3:0], rom[mpc]});
`ifdef FETCH_HALT_DETECT_EN
          if (rom[mpc][7:4] == 4'b0111) mhalt = 1'b1;
          else mpc = (mpc + 1) % 16;
`else
          mpc = (mpc + 1) % 16;
`endif
        end
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("out_valid", int'(out_valid), int'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_pc", int'(out_pc), int'(mq[0][11:8]));
        chk("out_instr", int'(out_instr), int'(mq[0][7:0]));
      end
      chk("imem_addr", int'(imem_addr), mpc);
      chk("halted", int'(halted), int'(mhalt));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    demo[0] = 8'h05; demo[1] = 8'h03; demo[2] = 8'h21; demo[3] = 8'h02;
    demo[4] = 8'h32; demo[5] = 8'h41; demo[6] = 8'h51; demo[7] = 8'h70;
    for (int i = 0; i < 16; i++) rom[i] = (i < 8) ? demo[i] : 8'h00;

    // reset values
    tick();
    tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pc", int'(out_pc), 0);
    chk("rst_out_instr", int'(out_instr), 0);
    chk("rst_imem_addr", int'(imem_addr), 0);
    chk("rst_halted", int'(halted), 0);
    cmp_en = 1'b1;

    // demo program streams back-to-back
    en = 1'b1; out_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t1_valid", int'(out_valid), 1);
      chk("t1_pc", int'(out_pc), k);
      chk("t1_instr", int'(out_instr), int'(demo[k]));
    end
`ifdef FETCH_HALT_DETECT_EN
    chk("t4_halted", int'(halted), 1);
    chk("t4_addr", int'(imem_addr), 7);
    tick();
    chk("t4_drained", int'(out_valid), 0);
    chk("t4_addr_hold", int'(imem_addr), 7);
    redirect_valid = 1'b1; redirect_addr = 4'd0;
    tick();
    redirect_valid = 1'b0;
    chk("t4_unhalt", int'(halted), 0);
    tick();
    chk("t4_restart_pc", int'(out_pc), 0);
    chk("t4_restart_instr", int'(out_instr), 8'h05);
`else
    chk("t5_addr8", int'(imem_addr), 8);
    for (int k = 0; k < 8; k++) tick();
    chk("t5_wrap", int'(imem_addr), 0);
    chk("t5_pc15", int'(out_pc), 15);
    chk("t5_halted", int'(halted), 0);
`endif

    // backpressure fills the queue, then drains without gaps
    en = 1'b1; out_ready = 1'b0;
    do_reset();
    tick(); tick(); tick();
    chk("t2_valid", int'(out_valid), 1);
    chk("t2_head", int'(out_pc), 0);
    chk("t2_addr", int'(imem_addr), 2);
    out_ready = 1'b1;
    chk("t2_d0", int'(out_instr), 8'h05);
    tick();
    chk("t2_d1", int'(out_pc), 1);
    chk("t2_d1i", int'(out_instr), 8'h03);
    tick();
    chk("t2_d2", int'(out_pc), 2);
    chk("t2_d2i", int'(out_instr), 8'h21);

    // redirect flushes queued entries, also when coincident with a pop
    out_ready = 1'b0;
    do_reset();
    tick(); tick();
    redirect_valid = 1'b1; redirect_addr = 4'd5;
    tick();
    redirect_valid = 1'b0;
    chk("t3_flushed", int'(out_valid), 0);
    chk("t3_addr", int'(imem_addr), 5);
    tick();
    chk("t3_pc5", int'(out_pc), 5);
    chk("t3_i5", int'(out_instr), 8'h41);
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 4'd2;
    tick();
    redirect_valid = 1'b0;
    chk("t3_popflush", int'(out_valid), 0);
    tick();
    chk("t3_pc2", int'(out_pc), 2);
    chk("t3_i2", int'(out_instr), 8'h21);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    do_reset();
    tick(); tick();
    redirect_valid = 1'b1; redirect_addr = 4'd3;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    chk("t6_pre_addr", int'(imem_addr), 5);
    chk("t6_pre_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_addr", int'(imem_addr), 0);
    chk("t6_pc", int'(out_pc), 0);
    tick();
    rst_n = 1'b1;

    // randomized run against the model
    for (int i = 0; i < 16; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(3) == 0) r[7:4] = 4'b0111;
      rom[i] = r;
    end
    for (int c = 0; c < 3000; c++) begin
      en             = ($urandom_range(7) != 0);
      out_ready      = ($urandom_range(2) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_addr  = 4'($urandom);
      tick();
    end
    redirect_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
